fp16_argmax_stream: RTL and testbench
=====================================

Name: fp16_argmax_stream

Overview:
Streaming reduction unit that consumes a vector of FP16 values, one element per cycle over a valid/ready handshake. It returns the extreme element (max or min), its index, and the element count. It sits downstream of the datapath pipe stages, e.g. softmax/top-1 selection, and uses the team's FP16 ordering rule via a comparator sub-module. Output is a single result beat per vector, held until accepted.

Parameters:
IDX_W, 8, index width; maximum vector length 2^IDX_W elements
WIDTH, 16, element width (fixed FP16: 1 sign, 5 exponent, 10 mantissa)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
mode_i  in  1  0 = max, 1 = min; sampled with the first element of each vector
in_valid_i  in  1  input element valid
in_ready_o  out  1  unit can accept an element
in_data_i  in  WIDTH  FP16 element
in_last_i  in  1  element is the last of the vector
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts result
out_value_o  out  WIDTH  extreme element (raw bits)
out_idx_o  out  IDX_W  index of extreme element (0-based)
out_count_o  out  IDX_W+1  number of elements in the vector
out_trunc_o  out  1  vector was force-terminated at max length without in_last_i

Behaviour:
- Ordering is a total order on raw bits, sign-magnitude:
  - Sign 0 beats sign 1.
  - Same sign: compare {exp, man} unsigned; larger magnitude wins for positive, smaller magnitude wins for negative.
  - -0 < +0.
  - NaN/Inf get no special handling; they are ordered by bit pattern.
- Strict comparison: a new element replaces the held one only if strictly greater (max) or strictly less (min). Ties keep the earliest index.
- Reset: all outputs 0 (out_valid_o=0, out_value_o=0, out_idx_o=0, out_count_o=0, out_trunc_o=0). State=IDLE. Registers cleared. in_ready_o=0 during reset.
- State FIRST (post-reset idle): in_ready_o=1.
  - On handshake: load value, idx=0, cnt=1, latch mode_i.
  - in_last_i=1 -> DONE; else -> ACCUM.
- State ACCUM: in_ready_o=1.
  - On handshake: compare against the held value and update value/idx if it wins. cnt+=1.
  - Go to DONE if in_last_i=1, or if this element's index = 2^IDX_W-1. In the second case out_trunc_o=1 unless in_last_i=1.
  - No handshake: hold all state.
- State DONE: in_ready_o=0, out_valid_o=1. Outputs are stable until out_ready_i=1.
  - On output handshake: next cycle FIRST, out_valid_o=0, trunc flag cleared.
- Latency: the last element is accepted at edge N; out_valid_o is high in the cycle after edge N. After output accept, in_ready_o is high in the following cycle. Throughput is one element/cycle within a vector, with one bubble per vector.
- mode_i is ignored after the first element; changing it mid-vector has no effect.
- in_data_i and in_last_i are ignored when in_valid_i=0 or in_ready_o=0.
- Asynchronous reset mid-vector discards partial state immediately; no result is emitted.
- out_count_o reaches 2^IDX_W at a truncated full-length vector, hence the IDX_W+1 width.

Decomposition:
- Shared package fp16_pkg holds:
  - WIDTH, EXP_BITS=5, MAN_BITS=10
  - typedef fp16_t (packed struct sign/exponent/mantissa)
  - enum argmax_state_e {FIRST, ACCUM, DONE}
- One combinational sub-module fp16_order_gt: inputs a, b; output a_gt_b under the ordering above, strict, so equal bit patterns give 0.
- Min mode reuses the same sub-module with operands swapped.
- Top-level holds the FSM, value/idx/count registers and the handshake logic.

Test Plan:
- Max, vector {0x3C00(1.0), 0x4000(2.0), 0xC000(-2.0), 0x3800(0.5)}, last on 4th -> value=0x4000, idx=1, count=4, trunc=0, out_valid one cycle after last accept.
- Min, same vector -> value=0xC000, idx=2, count=4.
- Ties and zero: max over {0x8000(-0), 0x0000(+0), 0x0000} -> value=0x0000, idx=1. Max over {0x4200, 0x4200} -> idx=0.
- Single element 0xBC00 with last on the first beat -> value=0xBC00, idx=0, count=1. Hold out_ready_i=0 for 5 cycles -> outputs stable, in_ready_o=0 throughout.
- IDX_W=3, 8 elements of 0x3C00 with last never asserted -> DONE after the 8th element, count=8, idx=0, trunc=1. The 9th element is not accepted until the output handshake.
- Randomized valid gaps and out_ready_i back-pressure, plus rst_ni pulsed mid-vector -> outputs 0 immediately. The next vector's result is unaffected by the partial vector.

Source files
------------

// File: rtl/fp16_pkg.sv
// FP16 field layout and FSM states shared by the argmax stream unit
// and its order comparator.
package fp16_pkg;

  localparam int WIDTH    = 16;
  localparam int EXP_BITS = 5;
  localparam int MAN_BITS = 10;

  typedef struct packed {
    logic                sign;
    logic [EXP_BITS-1:0] exponent;
    logic [MAN_BITS-1:0] mantissa;
  } fp16_t;

  typedef enum logic [1:0] {
    FIRST,
    ACCUM,
    DONE
  } argmax_state_e;

endpackage

// File: rtl/fp16_order_gt.sv
// Strict FP16 "a > b" under the sign-magnitude total order on raw bits
// (-0 < +0, NaN/Inf ordered purely by bit pattern).
module fp16_order_gt
  import fp16_pkg::*;
(
  input  fp16_t a,
  input  fp16_t b,
  output logic  a_gt_b
);

  logic [EXP_BITS+MAN_BITS-1:0] mag_a;
  logic [EXP_BITS+MAN_BITS-1:0] mag_b;

  assign mag_a = {a.exponent, a.mantissa};
  assign mag_b = {b.exponent, b.mantissa};

  // Between negatives the smaller magnitude is the larger number.
  always_comb begin
    if (a.sign != b.sign) begin
      a_gt_b = b.sign;
    end else if (!a.sign) begin
      a_gt_b = (mag_a > mag_b);
    end else begin
      a_gt_b = (mag_a < mag_b);
    end
  end

endmodule

// File: rtl/fp16_argmax_stream.sv
// Streaming FP16 max/min reduction: one element per cycle in, one
// value/index/count result beat per vector out, held until accepted.
module fp16_argmax_stream #(
  parameter int IDX_W = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             mode_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_value_o,
  output logic [IDX_W-1:0] out_idx_o,
  output logic [IDX_W:0]   out_count_o,
  output logic             out_trunc_o
);

  import fp16_pkg::*;

  argmax_state_e    state_q, state_d;
  logic [WIDTH-1:0] value_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W:0]   cnt_q;
  logic             mode_q;
  logic             trunc_q;

  logic  in_fire;
  logic  at_limit;
  logic  new_wins;
  fp16_t cmp_a;
  fp16_t cmp_b;

  // in_ready_o is gated by rst_ni so it stays low while reset is held.
  assign in_ready_o  = rst_ni && (state_q != DONE);
  assign out_valid_o = (state_q == DONE);
  assign in_fire     = in_valid_i && in_ready_o;
  assign at_limit    = (cnt_q == {1'b0, {IDX_W{1'b1}}});

  // Min mode swaps the operands so a single strict comparator serves both.
  assign cmp_a = mode_q ? fp16_t'(value_q)   : fp16_t'(in_data_i);
  assign cmp_b = mode_q ? fp16_t'(in_data_i) : fp16_t'(value_q);

  fp16_order_gt u_order_gt (
    .a      (cmp_a),
    .b      (cmp_b),
    .a_gt_b (new_wins)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FIRST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FIRST: begin
        if (in_fire) begin
          state_d = in_last_i ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_fire && (in_last_i || at_limit)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = FIRST;
        end
      end
      default: state_d = FIRST;
    endcase
  end

  // The held index of a new element is the running count before increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      unique case (state_q)
        FIRST: begin
          if (in_fire) begin
            value_q <= in_data_i;
            idx_q   <= '0;
            cnt_q   <= (IDX_W+1)'(1);
            mode_q  <= mode_i;
            trunc_q <= 1'b0;
          end
        end
        ACCUM: begin
          if (in_fire) begin
            if (new_wins) begin
              value_q <= in_data_i;
              idx_q   <= cnt_q[IDX_W-1:0];
            end
            cnt_q <= cnt_q + (IDX_W+1)'(1);
            if (at_limit && !in_last_i) begin
              trunc_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready_i) begin
            trunc_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_value_o = value_q;
  assign out_idx_o   = idx_q;
  assign out_count_o = cnt_q;
  assign out_trunc_o = trunc_q;

endmodule

// File: tb/tb_fp16_argmax_stream.sv
// Self-checking bench for fp16_argmax_stream (IDX_W=3) against an
// order-key reference model, with directed and randomized vectors.
module tb_fp16_argmax_stream;

  localparam int IDX_W = 3;
  localparam int WIDTH = 16;
  localparam int MAX_LEN = 1 << IDX_W;

  logic             clk_i;
  logic             rst_ni;
  logic             mode_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_data_i;
  logic             in_last_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_value_o;
  logic [IDX_W-1:0] out_idx_o;
  logic [IDX_W:0]   out_count_o;
  logic             out_trunc_o;

  int vectors;
  int miscompares;

  fp16_argmax_stream #(
    .IDX_W (IDX_W),
    .WIDTH (WIDTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .mode_i      (mode_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_value_o (out_value_o),
    .out_idx_o   (out_idx_o),
    .out_count_o (out_count_o),
    .out_trunc_o (out_trunc_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Maps an FP16 bit pattern onto an integer whose natural order is the
  // sign-magnitude total order: all negatives below -0 < +0 below positives.
  function automatic int order_key(input logic [15:0] v);
    int mag;
    mag = int'({17'd0, v[14:0]});
    return v[15] ? (32'h7FFF - mag) : (32'h8000 + mag);
  endfunction

  function automatic int model_best(input logic [15:0] elems[$], input logic m);
    int best;
    best = 0;
    for (int i = 1; i < elems.size(); i++) begin
      if (m ? (order_key(elems[i]) < order_key(elems[best]))
            : (order_key(elems[i]) > order_key(elems[best])))
        best = i;
    end
    return best;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents one element at a negedge and returns at the negedge after it is taken.
  task automatic applyStimulus(input logic [15:0] d, input logic last, input logic m);
    int waited;
    waited     = 0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = last;
    mode_i     = m;
    while (!in_ready_o && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    checkOutput("in_ready", in_ready_o, 1);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    in_data_i  = 16'($urandom);
    in_last_i  = 1'($urandom);
    mode_i     = 1'($urandom);
  endtask

  task automatic sendVector(input logic [15:0] elems[$], input logic m,
                            input bit mark_last, input int max_gap);
    foreach (elems[i]) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk_i);
      applyStimulus(elems[i], mark_last && (i == elems.size() - 1),
                    (i == 0) ? m : 1'($urandom));
    end
  endtask

  task automatic checkFields(input logic [15:0] ev, input int ei, input int ec,
                             input bit et);
    checkOutput("out_value", out_value_o, ev);
    checkOutput("out_idx",   out_idx_o,   ei);
    checkOutput("out_count", out_count_o, ec);
    checkOutput("out_trunc", out_trunc_o, et);
  endtask

  // Entered at the negedge right after the last accept, so out_valid must already be high.
  task automatic collectResult(input logic [15:0] ev, input int ei, input int ec,
                               input bit et, input int stall);
    out_ready_i = 1'b0;
    checkOutput("out_valid", out_valid_o, 1);
    checkFields(ev, ei, ec, et);
    repeat (stall) begin
      @(negedge clk_i);
      checkOutput("stall_valid", out_valid_o, 1);
      checkOutput("stall_in_ready", in_ready_o, 0);
      checkFields(ev, ei, ec, et);
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    checkOutput("post_valid", out_valid_o, 0);
    checkOutput("post_in_ready", in_ready_o, 1);
    checkOutput("post_trunc", out_trunc_o, 0);
  endtask

  initial begin
    logic [15:0] elems[$];
    logic [15:0] pool[4];
    int          len;
    int          best;
    logic        m;
    bit          trunc;

    vectors     = 0;
    miscompares = 0;
    pool[0] = 16'h0000;
    pool[1] = 16'h8000;
    pool[2] = 16'h3C00;
    pool[3] = 16'hBC00;

    rst_ni      = 1'b0;
    mode_i      = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    in_last_i   = 1'b0;
    out_ready_i = 1'b0;

    #2;
    checkOutput("rst_in_ready",  in_ready_o,  0);
    checkOutput("rst_out_valid", out_valid_o, 0);
    checkFields(16'h0000, 0, 0, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    checkOutput("first_in_ready", in_ready_o, 1);
    @(negedge clk_i);

    $display("[TB] directed max/min vectors");
    elems = {16'h3C00, 16'h4000, 16'hC000, 16'h3800};
    sendVector(elems, 1'b0, 1'b1, 0);
    collectResult(16'h4000, 1, 4, 1'b0, 0);
    sendVector(elems, 1'b1, 1'b1, 1);
    collectResult(16'hC000, 2, 4, 1'b0, 1);

    $display("[TB] ties and signed zero");
    elems = {16'h8000, 16'h0000, 16'h0000};
    sendVector(elems, 1'b0, 1'b1, 0);
    collectResult(16'h0000, 1, 3, 1'b0, 0);
    elems = {16'h4200, 16'h4200};
    sendVector(elems, 1'b0, 1'b1, 0);
    collectResult(16'h4200, 0, 2, 1'b0, 0);

    $display("[TB] single element with output back-pressure");
    applyStimulus(16'hBC00, 1'b1, 1'b0);
    collectResult(16'hBC00, 0, 1, 1'b0, 5);

    $display("[TB] full-length vectors");
    elems = {16'h4000, 16'h3C00, 16'h3800, 16'h3800,
             16'hBC00, 16'hBC00, 16'hC000, 16'hC000};
    sendVector(elems, 1'b1, 1'b1, 0);
    collectResult(16'hC000, 6, 8, 1'b0, 0);
    elems = {16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00,
             16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
    sendVector(elems, 1'b0, 1'b0, 0);
    in_valid_i = 1'b1;
    in_data_i  = 16'h4000;
    in_last_i  = 1'b1;
    mode_i     = 1'b0;
    collectResult(16'h3C00, 0, 8, 1'b1, 3);
    applyStimulus(16'h4000, 1'b1, 1'b0);
    collectResult(16'h4000, 0, 1, 1'b0, 0);

    $display("[TB] reset mid-vector");
    elems = {16'h4000, 16'h5000, 16'h3000};
    sendVector(elems, 1'b0, 1'b0, 0);
    rst_ni = 1'b0;
    #1;
    checkOutput("midrst_in_ready",  in_ready_o,  0);
    checkOutput("midrst_out_valid", out_valid_o, 0);
    checkFields(16'h0000, 0, 0, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    applyStimulus(16'h3800, 1'b1, 1'b0);
    collectResult(16'h3800, 0, 1, 1'b0, 0);

    $display("[TB] randomized vectors");
    for (int v = 0; v < 40; v++) begin
      len   = $urandom_range(1, MAX_LEN + 1);
      trunc = (len > MAX_LEN);
      if (trunc) len = MAX_LEN;
      m     = 1'($urandom);
      elems = {};
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 2) == 0) elems.push_back(pool[$urandom_range(0, 3)]);
        else elems.push_back(16'($urandom));
      end
      best = model_best(elems, m);
      sendVector(elems, m, !trunc, 2);
      collectResult(elems[best], best, len, trunc, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
